// File: rtl/lsu_unit.sv
// Load/store unit: one B/H/W access per request on a req/ack data-memory port, extended load data to writeback.
// Latency: accept at edge 0, mem_req in cycle 1, ack in cycle N gives done/wb_valid in cycle N+1; errors give done in cycle 1.
// Backpressure: req_ready drops from accept until the access retires; upstream holds req_valid while it is low.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   req_valid/req_ready       execute-stage handshake; req_we, req_funct3, req_addr, req_wdata, req_rd describe the access
//   mem_req/mem_ack           data-memory request (held until ack) and single-cycle completion
//   mem_we, mem_addr, mem_wstrb, mem_wdata, mem_rdata   word-aligned memory data path
//   wb_valid, wb_rd, wb_data  load result to writeback (held when wb_valid=0)
//   done, err_misalign, err_illegal, err_bus           retire pulse with error qualifiers
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        err_misalign,
  output logic        err_illegal,
  output logic        err_bus
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  // Fields of the in-flight access needed when the ack comes back.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] a;
    logic [4:0] rd;
  } acc_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  acc_t        acc_q, acc_d;

  logic        req_ready_d, mem_req_d, mem_we_d, wb_valid_d, done_d;
  logic        err_misalign_d, err_illegal_d, err_bus_d;
  logic [31:0] mem_addr_d, mem_wdata_d, wb_data_d;
  logic [3:0]  mem_wstrb_d;
  logic [4:0]  wb_rd_d;

  logic        chk_illegal, chk_misalign;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{a, 3'b000} +: 8];
    h = rdata[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Accept-time checks; illegal takes priority over misaligned.
  always_comb begin
    chk_illegal  = 1'b1;
    chk_misalign = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: chk_illegal = 1'b0;
      3'b100, 3'b101:         chk_illegal = req_we;
      default:                chk_illegal = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b01:   chk_misalign = req_addr[0];
      2'b10:   chk_misalign = (req_addr[1:0] != 2'b00);
      default: chk_misalign = 1'b0;
    endcase
  end

  // Store lane placement: replicate data across the word, strobes select the lanes.
  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = 32'h0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_strb  = 4'b0001 << req_addr[1:0];
          st_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_strb  = 4'b0011 << req_addr[1:0];
          st_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          st_strb  = 4'b1111;
          st_wdata = req_wdata;
        end
      endcase
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    req_ready_d    = req_ready;
    mem_req_d      = mem_req;
    mem_we_d       = mem_we;
    mem_addr_d     = mem_addr;
    mem_wstrb_d    = mem_wstrb;
    mem_wdata_d    = mem_wdata;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd;
    wb_data_d      = wb_data;
    done_d         = 1'b0;
    err_misalign_d = 1'b0;
    err_illegal_d  = 1'b0;
    err_bus_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          acc_d       = '{we: req_we, funct3: req_funct3, a: req_addr[1:0], rd: req_rd};
          req_ready_d = 1'b0;
          cnt_d       = 8'd0;
          if (chk_illegal) begin
            err_illegal_d = 1'b1;
            done_d        = 1'b1;
            state_d       = S_RESP;
          end else if (chk_misalign) begin
            err_misalign_d = 1'b1;
            done_d         = 1'b1;
            state_d        = S_RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wstrb_d = st_strb;
            mem_wdata_d = st_wdata;
            state_d     = S_REQ;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Ack wins over a timeout reached in the same cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          cnt_d     = 8'd0;
          state_d   = S_RESP;
          if (!acc_q.we) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = acc_q.rd;
            wb_data_d  = load_extract(mem_rdata, acc_q.funct3, acc_q.a);
          end
        end else if ((cnt_q + 8'd1) == TO_LIM) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_bus_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      acc_q        <= '0;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wstrb    <= 4'b0000;
      mem_wdata    <= 32'h0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0;
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_illegal  <= 1'b0;
      err_bus      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      req_ready    <= req_ready_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wstrb    <= mem_wstrb_d;
      mem_wdata    <= mem_wdata_d;
      wb_valid     <= wb_valid_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
      done         <= done_d;
      err_misalign <= err_misalign_d;
      err_illegal  <= err_illegal_d;
      err_bus      <= err_bus_d;
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit with TIMEOUT_CYCLES=4.
// Inputs are driven and outputs sampled 1ns after the rising edge.
// Memory acks are issued by the bench in a chosen REQ cycle, or never for the timeout cases.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done, err_misalign, err_illegal, err_bus;

  int checks = 0;
  int failures = 0;

  // Observations recorded by do_access.
  int          r_req_cyc, r_done_cyc;
  logic        r_done_seen, r_wb, r_errm, r_erri, r_errb, r_we, r_rdy;
  logic [31:0] r_addr, r_wdata, r_wb_data;
  logic [3:0]  r_wstrb;
  logic [4:0]  r_wb_rd;

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .err_misalign(err_misalign), .err_illegal(err_illegal), .err_bus(err_bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access, ack it in REQ cycle ack_at (0 = never), record what the DUT did.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int ack_at, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    tick();
    req_valid = 1'b0;
    r_req_cyc = 0; r_done_cyc = 0; r_done_seen = 1'b0;
    r_wb = 1'b0; r_errm = 1'b0; r_erri = 1'b0; r_errb = 1'b0; r_we = 1'b0; r_rdy = 1'b1;
    r_addr = 32'h0; r_wdata = 32'h0; r_wstrb = 4'h0; r_wb_data = 32'h0; r_wb_rd = 5'd0;
    for (int cyc = 1; cyc <= 40 && !r_done_seen; cyc++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        r_req_cyc++;
        r_addr  = mem_addr;
        r_wstrb = mem_wstrb;
        r_wdata = mem_wdata;
        r_we    = mem_we;
        if (r_req_cyc == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (done) begin
        r_done_seen = 1'b1;
        r_done_cyc  = cyc;
        r_wb        = wb_valid;
        r_wb_data   = wb_data;
        r_wb_rd     = wb_rd;
        r_errm      = err_misalign;
        r_erri      = err_illegal;
        r_errb      = err_bus;
        r_rdy       = req_ready;
      end
      tick();
    end
    mem_ack = 1'b0;
    check_eq("done_seen", 32'(r_done_seen), 32'd1);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("wb_pulse", 32'(wb_valid), 32'd0);
    check_eq("rdy_in_resp", 32'(r_rdy), 32'd0);
    check_eq("rdy_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    // Reset state.
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_wstrb", 32'(mem_wstrb), 32'h0);
    check_eq("rst_wb_data", wb_data, 32'h0);
    check_eq("rst_done", 32'(done), 32'd0);

    // LW, ack after 3 REQ cycles.
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
    check_eq("lw_req_cyc", r_req_cyc, 3);
    check_eq("lw_done_cyc", r_done_cyc, 4);
    check_eq("lw_addr", r_addr, 32'h100);
    check_eq("lw_wstrb", 32'(r_wstrb), 32'h0);
    check_eq("lw_we", 32'(r_we), 32'd0);
    check_eq("lw_wb", 32'(r_wb), 32'd1);
    check_eq("lw_data", r_wb_data, 32'hDEADBEEF);
    check_eq("lw_rd", 32'(r_wb_rd), 32'd7);

    // LB / LBU at byte 3.
    do_access(1'b0, 3'b000, 32'h203, 32'h0, 5'd3, 1, 32'h80123456);
    check_eq("lb_done_cyc", r_done_cyc, 2);
    check_eq("lb_addr", r_addr, 32'h200);
    check_eq("lb_data", r_wb_data, 32'hFFFFFF80);
    do_access(1'b0, 3'b100, 32'h203, 32'h0, 5'd4, 1, 32'h80123456);
    check_eq("lbu_data", r_wb_data, 32'h00000080);
    check_eq("lbu_rd", 32'(r_wb_rd), 32'd4);

    // LH upper half / LHU lower half.
    do_access(1'b0, 3'b001, 32'h002, 32'h0, 5'd5, 2, 32'h80017FFF);
    check_eq("lh_data", r_wb_data, 32'hFFFF8001);
    do_access(1'b0, 3'b101, 32'h000, 32'h0, 5'd6, 1, 32'h80017FFF);
    check_eq("lhu_data", r_wb_data, 32'h00007FFF);

    // SH at half 1; writeback must hold the LHU result.
    do_access(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 5'd9, 1, 32'h0);
    check_eq("sh_addr", r_addr, 32'h300);
    check_eq("sh_wstrb", 32'(r_wstrb), 32'hC);
    check_eq("sh_wdata", r_wdata, 32'hABCDABCD);
    check_eq("sh_we", 32'(r_we), 32'd1);
    check_eq("sh_wb", 32'(r_wb), 32'd0);
    check_eq("sh_hold_data", r_wb_data, 32'h00007FFF);
    check_eq("sh_hold_rd", 32'(r_wb_rd), 32'd6);

    // SB at byte 1 and SW.
    do_access(1'b1, 3'b000, 32'h401, 32'h12345678, 5'd1, 1, 32'h0);
    check_eq("sb_wstrb", 32'(r_wstrb), 32'h2);
    check_eq("sb_wdata", r_wdata, 32'h78787878);
    do_access(1'b1, 3'b010, 32'h410, 32'hCAFEF00D, 5'd1, 1, 32'h0);
    check_eq("sw_wstrb", 32'(r_wstrb), 32'hF);
    check_eq("sw_wdata", r_wdata, 32'hCAFEF00D);

    // Misaligned LW.
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 5'd2, 1, 32'h11111111);
    check_eq("mis_req_cyc", r_req_cyc, 0);
    check_eq("mis_done_cyc", r_done_cyc, 1);
    check_eq("mis_err", 32'(r_errm), 32'd1);
    check_eq("mis_ill", 32'(r_erri), 32'd0);
    check_eq("mis_wb", 32'(r_wb), 32'd0);
    check_eq("mis_hold", r_wb_data, 32'h00007FFF);

    // Misaligned LH.
    do_access(1'b0, 3'b001, 32'h003, 32'h0, 5'd2, 1, 32'h0);
    check_eq("mis_lh_err", 32'(r_errm), 32'd1);

    // Illegal store funct3=100.
    do_access(1'b1, 3'b100, 32'h500, 32'h0, 5'd2, 1, 32'h0);
    check_eq("ill_req_cyc", r_req_cyc, 0);
    check_eq("ill_done_cyc", r_done_cyc, 1);
    check_eq("ill_err", 32'(r_erri), 32'd1);

    // Illegal load funct3=110 on an odd address: illegal wins over misaligned.
    do_access(1'b0, 3'b110, 32'h501, 32'h0, 5'd2, 1, 32'h0);
    check_eq("ill_prio_ill", 32'(r_erri), 32'd1);
    check_eq("ill_prio_mis", 32'(r_errm), 32'd0);

    // Timeout: no ack.
    do_access(1'b0, 3'b010, 32'h600, 32'h0, 5'd8, 0, 32'h0);
    check_eq("to_req_cyc", r_req_cyc, 4);
    check_eq("to_done_cyc", r_done_cyc, 5);
    check_eq("to_err", 32'(r_errb), 32'd1);
    check_eq("to_wb", 32'(r_wb), 32'd0);

    // Ack in the 4th REQ cycle beats the timeout.
    do_access(1'b0, 3'b010, 32'h700, 32'h0, 5'd10, 4, 32'h01020304);
    check_eq("ack4_req_cyc", r_req_cyc, 4);
    check_eq("ack4_err", 32'(r_errb), 32'd0);
    check_eq("ack4_wb", 32'(r_wb), 32'd1);
    check_eq("ack4_data", r_wb_data, 32'h01020304);

    // Ack while idle is ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("idle_ack_done", 32'(done), 32'd0);
    check_eq("idle_ack_wb", 32'(wb_valid), 32'd0);

    // Reset while in REQ, then a stale ack.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h800;
    req_rd     = 5'd11;
    tick();
    req_valid = 1'b0;
    check_eq("rr_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rr_mem_req_low", 32'(mem_req), 32'd0);
    check_eq("rr_ready", 32'(req_ready), 32'd1);
    check_eq("rr_wb_data", wb_data, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBADBAD00;
    tick();
    mem_ack = 1'b0;
    check_eq("rr_stale_done", 32'(done), 32'd0);
    check_eq("rr_stale_wb", 32'(wb_valid), 32'd0);
    tick();
    check_eq("rr_stale_done2", 32'(done), 32'd0);
    check_eq("rr_stale_wb2", 32'(wb_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
